instruction_queue_decoder: RTL
==============================

Name: instruction_queue_decoder

Overview:
Parametrised successor to the single-instruction decoder. It assembles a byte stream from the host bus into instructions of 1..INSTR_BYTES bytes, with either fixed or opcode-encoded variable length. Completed instructions go into a DEPTH-entry show-ahead FIFO, which is drained by the GPU execution unit over a valid/ready handshake. It sits between the host byte port and the command executor; the executor can now stall without the host losing instructions.

Parameters:
INSTR_BYTES, 4, maximum instruction length in bytes (1..8); instruction bus width W = 8*INSTR_BYTES
DEPTH, 4, FIFO entries (power of two, 2..16)
VAR_LEN, 0, 0 = every instruction is INSTR_BYTES long; 1 = length taken from opcode bits [7:6]

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_en  in  1  byte port enable
i_we  in  1  byte port write strobe
i_data  in  8  instruction byte
o_ack  out  1  one-cycle pulse, cycle after a byte is accepted
o_busy  out  1  FIFO full; bytes rejected
i_abort  in  1  discard partially assembled instruction
o_instruction  out  W  FIFO head instruction; zero when o_valid=0
o_length  out  4  byte count of head instruction (1..INSTR_BYTES); zero when o_valid=0
o_valid  out  1  head entry valid
i_ready  in  1  consumer accepts head this cycle
o_count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (sampled on i_clk edge) clears: FIFO pointers and count, assembler state to IDLE, byte counter, assembly register. Outputs after reset: o_ack=0, o_busy=0, o_valid=0, o_instruction=0, o_length=0, o_count=0.
- Byte accept: accept = i_en && i_we && !o_busy && !i_abort. o_ack is a registered copy of accept, so it is high exactly one cycle after each accepted byte.
- o_busy = (count == DEPTH), decoded from registered count. While full, a simultaneous pop does not unblock the same cycle; the byte is rejected and the host must retry.
- Assembler FSM:
  - IDLE: an accepted byte is the opcode. It is stored in bits [W-1:W-8] and the remaining bits are cleared.
    - Target length L = INSTR_BYTES if VAR_LEN=0.
    - If VAR_LEN=1, L = min(opcode[7:6]+1, INSTR_BYTES).
    - If L==1, push immediately and stay in IDLE. Otherwise go to COLLECT with idx=1.
  - COLLECT: an accepted byte k (0-based) is stored in bits [W-1-8k : W-8-8k] (big-endian, first byte in MSBs). Unreceived low bytes stay zero.
    - When idx==L-1, push to the FIFO and return to IDLE. Otherwise idx++.
- Push timing: the push happens on the same edge that samples the final byte. The entry is visible at the head from the next cycle if the FIFO was empty, so latency from the final byte strobe to o_valid is 1 cycle.
- Push never happens while full; this is guaranteed by the o_busy gating.
- i_abort: highest priority after reset. It forces IDLE, clears the assembly register and idx, and accepts no byte that cycle. FIFO contents are untouched.
- Pop: o_valid && i_ready advances the read pointer. o_instruction and o_length are driven from the FIFO head (show-ahead), gated to zero when empty.
- Push and pop in the same cycle: count is unchanged and both pointers advance. When count==1, the new entry becomes the head next cycle and o_valid stays high.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- i_ready while o_valid=0 has no effect.
- Reset mid-assembly or with entries queued discards everything, with no o_ack after reset.

Test Plan:
- Fixed length (INSTR_BYTES=4, VAR_LEN=0): strobe 0x12,0x34,0x56,0x78 with i_ready=1 -> o_ack pulses 4 times; o_valid for 1 cycle with o_instruction=0x12345678 and o_length=4; o_count returns to 0.
- Variable length (VAR_LEN=1): bytes 0x05 | 0x80,0xAA,0xBB | 0xC1,1,2,3 -> three entries 0x05000000/len1, 0x80AABB00/len3, 0xC1010203/len4, popped in order.
- Back-pressure (DEPTH=4, i_ready=0): send 5 fixed instructions -> o_count reaches 4 and o_busy=1; bytes of the 5th get no o_ack. Raise i_ready for 1 cycle -> count 3, busy clears; the resent 5th completes and order is preserved.
- Simultaneous push/pop at count=1: final byte strobe coincides with a pop -> o_count stays 1, o_valid stays high, head changes to the new instruction next cycle.
- Abort: send 0x11,0x22, assert i_abort, then 0xDE,0xAD,0xBE,0xEF -> single entry 0xDEADBEEF; no o_ack in the abort cycle.
- Reset mid-operation: 2 entries queued plus 2 bytes assembled, pulse i_reset -> next cycle o_valid=0, o_count=0, o_instruction=0, o_busy=0; a subsequent instruction assembles from byte 0.

Source files
------------

// File: rtl/instruction_queue_decoder.sv
// Host byte-stream instruction assembler feeding a show-ahead FIFO.
// Bytes are packed big-endian into instructions of 1..INSTR_BYTES bytes
// (fixed length, or length taken from opcode bits [7:6]). Finished
// instructions are queued for the execution unit, which drains them over
// a valid/ready handshake.
module instruction_queue_decoder #(
  parameter int unsigned INSTR_BYTES = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned VAR_LEN     = 0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_en,
  input  logic                       i_we,
  input  logic [7:0]                 i_data,
  output logic                       o_ack,
  output logic                       o_busy,
  input  logic                       i_abort,
  output logic [8*INSTR_BYTES-1:0]   o_instruction,
  output logic [3:0]                 o_length,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned W  = 8 * INSTR_BYTES;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } state_t;

  // Assembler state
  state_t         r_state;
  state_t         w_state_next;
  logic [3:0]     r_idx;
  logic [3:0]     w_idx_next;
  logic [3:0]     r_len;
  logic [3:0]     w_len_next;
  logic [W-1:0]   r_asm;
  logic [W-1:0]   w_asm_next;
  logic           r_ack;

  // Handshake / push interface into the FIFO
  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic [W-1:0]   w_push_data;
  logic [3:0]     w_push_len;
  logic [3:0]     w_op_len;

  // FIFO storage and pointers
  logic [W-1:0]   r_mem_instr [DEPTH];
  logic [3:0]     r_mem_len   [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;

  assign o_busy   = (r_count == CW'(DEPTH));
  assign o_valid  = (r_count != '0);
  assign o_count  = r_count;
  assign o_ack    = r_ack;
  assign w_accept = i_en & i_we & ~o_busy & ~i_abort;
  assign w_pop    = o_valid & i_ready;

  // Target length decoded from a byte arriving as opcode
  always_comb begin
    w_op_len = 4'(INSTR_BYTES);
    if ((VAR_LEN != 0) && (({2'b00, i_data[7:6]} + 4'd1) < 4'(INSTR_BYTES))) begin
      w_op_len = {2'b00, i_data[7:6]} + 4'd1;
    end
  end

  // Assembler next-state, byte placement and push generation
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_len_next   = r_len;
    w_asm_next   = r_asm;
    w_push       = 1'b0;
    w_push_data  = r_asm;
    w_push_len   = r_len;
    if (i_abort) begin
      w_state_next = ST_IDLE;
      w_idx_next   = '0;
      w_asm_next   = '0;
    end else if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          w_asm_next          = '0;
          w_asm_next[W-1 -: 8] = i_data;
          if (w_op_len == 4'd1) begin
            w_push      = 1'b1;
            w_push_data = w_asm_next;
            w_push_len  = 4'd1;
            w_asm_next  = '0;
          end else begin
            w_state_next = ST_COLLECT;
            w_idx_next   = 4'd1;
            w_len_next   = w_op_len;
          end
        end
        ST_COLLECT: begin
          for (int unsigned k = 1; k < INSTR_BYTES; k++) begin
            if (r_idx == 4'(k)) begin
              w_asm_next[W-1-8*k -: 8] = i_data;
            end
          end
          if (r_idx == (r_len - 4'd1)) begin
            // Snapshot the completed word before the register is cleared
            w_push       = 1'b1;
            w_push_data  = w_asm_next;
            w_push_len   = r_len;
            w_state_next = ST_IDLE;
            w_idx_next   = '0;
            w_asm_next   = '0;
          end else begin
            w_idx_next = r_idx + 4'd1;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_idx_next   = '0;
          w_asm_next   = '0;
        end
      endcase
    end
  end

  // Assembler state register and byte acknowledge
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_asm   <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_len   <= w_len_next;
      r_asm   <= w_asm_next;
      r_ack   <= w_accept;
    end
  end

  // FIFO storage write; contents are don't-care until counted valid
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_instr[r_wptr] <= w_push_data;
      r_mem_len[r_wptr]   <= w_push_len;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Show-ahead head outputs, forced to zero while empty
  always_comb begin
    o_instruction = '0;
    o_length      = '0;
    if (o_valid) begin
      o_instruction = r_mem_instr[r_rptr];
      o_length      = r_mem_len[r_rptr];
    end
  end

endmodule
